// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and width default for alu_multicycle (macro ALU_MULTICYCLE_DIV_EN)
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ILL   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_LUI   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_SLL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
`ifdef ALU_MULTICYCLE_DIV_EN
        ST_DIV_BUSY = 2'd2,
`endif
        ST_DONE     = 2'd3
    } state_t;

    // Multiplier ops always take the iterative path; DIVU/REMU only when the divider is built.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
`ifdef ALU_MULTICYCLE_DIV_EN
        return (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == 4'b0000) && (op != 4'b0000);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - shared shift-add multiply / restoring divide datapath with iteration counter (macro ALU_MULTICYCLE_DIV_EN)
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_MULTICYCLE_DIV_EN
    input  logic             div_mode,
`endif
    input  logic             busy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int CNT_W = SHAMT_W + 1;

    // hi/lo: product halves for multiply, remainder/quotient for divide.
    // opnd: multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic             mode_div;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // One iteration step: conditional add and shift right, or shift-left and trial subtract.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_MULTICYCLE_DIV_EN
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (mode_div) begin
            // A divisor of zero never borrows, leaving quotient all-ones and remainder A.
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Operand capture on acceptance, then one step and counter increment per busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            mode_div <= 1'b0;
`endif
        end else if (start) begin
            hi  <= '0;
            cnt <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            mode_div <= div_mode;
            if (div_mode) begin
                opnd <= b;
                lo   <= a;
            end else begin
                opnd <= a;
                lo   <= b;
            end
`else
            opnd <= a;
            lo   <= b;
`endif
        end else if (busy) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle ops and iterative MUL/MULHU (DIVU/REMU with macro ALU_MULTICYCLE_DIV_EN)
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    state_t             state;
    logic               sel_hi;
    logic               accept;
    logic               start;
    logic               busy;
    logic               iter_last;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [WIDTH-1:0]   iter_res;
    logic [WIDTH-1:0]   single_res;
    logic [31:0]        lui_word;
    logic [SHAMT_W-1:0] shamt;

    assign accept    = Valid_i && Ready_o;
    assign start     = accept && (is_mul_op(ALU_Operation_i) || is_div_op(ALU_Operation_i));
    assign shamt     = B_i[SHAMT_W-1:0];
    assign lui_word  = {B_i[19:0], 12'h000};
    assign iter_res  = sel_hi ? hi_next : lo_next;

    // Iteration unit advances only while in a busy state.
    always_comb begin
        busy = (state == ST_MUL_BUSY);
`ifdef ALU_MULTICYCLE_DIV_EN
        if (state == ST_DIV_BUSY) busy = 1'b1;
`endif
    end

    // Single-cycle result; multi-cycle and illegal opcodes fall through to zero.
    always_comb begin
        single_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_res = A_i + B_i;
            OP_SUB:  single_res = A_i - B_i;
            OP_SRL:  single_res = A_i >> shamt;
            OP_SRA:  single_res = $signed(A_i) >>> shamt;
            OP_AND:  single_res = A_i & B_i;
            OP_XOR:  single_res = A_i ^ B_i;
            OP_OR:   single_res = A_i | B_i;
            OP_SLL:  single_res = A_i << shamt;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, A_i < B_i};
            OP_LUI:  single_res = WIDTH'($signed(lui_word));
            default: single_res = '0;
        endcase
    end

    alu_iter_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef ALU_MULTICYCLE_DIV_EN
        .div_mode (is_div_op(ALU_Operation_i)),
`endif
        .busy     (busy),
        .a        (A_i),
        .b        (B_i),
        .last     (iter_last),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // Control FSM; result/Valid_o load on single-cycle acceptance or on the final iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            Ready_o      <= 1'b1;
            Valid_o      <= 1'b0;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
            sel_hi       <= 1'b0;
        end else begin
            Valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul_op(ALU_Operation_i)) begin
                            state   <= ST_MUL_BUSY;
                            Ready_o <= 1'b0;
                            sel_hi  <= (ALU_Operation_i == OP_MULHU);
`ifdef ALU_MULTICYCLE_DIV_EN
                        end else if (is_div_op(ALU_Operation_i)) begin
                            state   <= ST_DIV_BUSY;
                            Ready_o <= 1'b0;
                            sel_hi  <= (ALU_Operation_i == OP_REMU);
`endif
                        end else begin
                            Valid_o      <= 1'b1;
                            ALU_Result_o <= single_res;
                            Zero_o       <= (single_res == '0);
                        end
                    end
                end
`ifdef ALU_MULTICYCLE_DIV_EN
                ST_MUL_BUSY, ST_DIV_BUSY: begin
`else
                ST_MUL_BUSY: begin
`endif
                    if (iter_last) begin
                        state        <= ST_DONE;
                        Valid_o      <= 1'b1;
                        ALU_Result_o <= iter_res;
                        Zero_o       <= (iter_res == '0);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    Ready_o <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    Ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
